flash_user_arb: RTL and testbench

FLASH_USER_ARB -- requirements
Module: flash_user_arb

---
 rtl/flash_user_arb.sv | 172 +++++++++++++++++
 tb/tb_flash_user_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_user_arb.sv
// flash_user_arb: two-requester round-robin front end for a single flash driver.
// A granted requester owns the driver operation port, its write stream is
// forwarded from ISSUE through BUSY, and the driver read stream is returned to
// it from ACCEPTED through BUSY. A programmable idle gap follows every operation.
module flash_user_arb #(
  parameter int P_GAP = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester 0
  input  logic [1:0]  i_r0_op_type,
  input  logic [23:0] i_r0_op_addr,
  input  logic [8:0]  i_r0_op_num,
  input  logic        i_r0_op_valid,
  output logic        o_r0_op_ready,
  input  logic [7:0]  i_r0_write_data,
  input  logic        i_r0_write_sop,
  input  logic        i_r0_write_eop,
  input  logic        i_r0_write_valid,
  output logic [7:0]  o_r0_read_data,
  output logic        o_r0_read_sop,
  output logic        o_r0_read_eop,
  output logic        o_r0_read_valid,
  // requester 1
  input  logic [1:0]  i_r1_op_type,
  input  logic [23:0] i_r1_op_addr,
  input  logic [8:0]  i_r1_op_num,
  input  logic        i_r1_op_valid,
  output logic        o_r1_op_ready,
  input  logic [7:0]  i_r1_write_data,
  input  logic        i_r1_write_sop,
  input  logic        i_r1_write_eop,
  input  logic        i_r1_write_valid,
  output logic [7:0]  o_r1_read_data,
  output logic        o_r1_read_sop,
  output logic        o_r1_read_eop,
  output logic        o_r1_read_valid,
  // flash driver side
  output logic [1:0]  o_user_op_type,
  output logic [23:0] o_user_op_addr,
  output logic [8:0]  o_user_op_num,
  output logic        o_user_op_valid,
  input  logic        i_user_op_ready,
  output logic [7:0]  o_user_write_data,
  output logic        o_user_write_sop,
  output logic        o_user_write_eop,
  output logic        o_user_write_valid,
  input  logic [7:0]  i_user_read_data,
  input  logic        i_user_read_sop,
  input  logic        i_user_read_eop,
  input  logic        i_user_read_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ACCEPTED, S_BUSY, S_GAP
  } state_t;

  localparam int CW = (P_GAP > 1) ? $clog2(P_GAP) : 1;

  state_t         state_reg, state_next;
  logic           ptr_reg;      // last requester served (1 at reset, so r0 wins the first tie)
  logic           grant_reg;    // requester owning the current operation
  logic [1:0]     op_type_reg;
  logic [23:0]    op_addr_reg;
  logic [8:0]     op_num_reg;
  logic [CW-1:0]  gap_cnt_reg;

  logic any_req, winner, handshake, gap_done;
  logic wr_fwd, rd_fwd;

  assign any_req   = i_r0_op_valid | i_r1_op_valid;
  // A lone requester wins outright; on a tie the one not served last wins.
  assign winner    = (i_r0_op_valid & i_r1_op_valid) ? ~ptr_reg : i_r1_op_valid;
  assign handshake = (state_reg == S_ISSUE) & i_user_op_ready;
  assign gap_done  = (gap_cnt_reg == CW'(P_GAP - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (any_req)          state_next = S_ISSUE;
      S_ISSUE:    if (i_user_op_ready)  state_next = S_ACCEPTED;
      S_ACCEPTED: if (!i_user_op_ready) state_next = S_BUSY;
      S_BUSY:     if (i_user_op_ready)  state_next = (P_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:      if (gap_done)         state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  // Grant/operation capture, round-robin pointer and gap counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_reg     <= 1'b1;
      grant_reg   <= 1'b0;
      op_type_reg <= '0;
      op_addr_reg <= '0;
      op_num_reg  <= '0;
      gap_cnt_reg <= '0;
    end else begin
      // Fields are latched once here; later changes by the requester are ignored.
      if (state_reg == S_IDLE && any_req) begin
        grant_reg   <= winner;
        op_type_reg <= winner ? i_r1_op_type : i_r0_op_type;
        op_addr_reg <= winner ? i_r1_op_addr : i_r0_op_addr;
        op_num_reg  <= winner ? i_r1_op_num  : i_r0_op_num;
      end
      if (handshake) ptr_reg <= grant_reg;
      if (state_reg == S_GAP) gap_cnt_reg <= gap_done ? '0 : gap_cnt_reg + 1'b1;
      else                    gap_cnt_reg <= '0;
    end
  end

  // Output logic: op port, ready to the granted requester, stream steering
  always_comb begin
    wr_fwd             = 1'b0;
    rd_fwd             = 1'b0;
    o_user_op_type     = '0;
    o_user_op_addr     = '0;
    o_user_op_num      = '0;
    o_user_op_valid    = 1'b0;
    o_r0_op_ready      = 1'b0;
    o_r1_op_ready      = 1'b0;
    o_user_write_data  = '0;
    o_user_write_sop   = 1'b0;
    o_user_write_eop   = 1'b0;
    o_user_write_valid = 1'b0;
    o_r0_read_data     = '0;
    o_r0_read_sop      = 1'b0;
    o_r0_read_eop      = 1'b0;
    o_r0_read_valid    = 1'b0;
    o_r1_read_data     = '0;
    o_r1_read_sop      = 1'b0;
    o_r1_read_eop      = 1'b0;
    o_r1_read_valid    = 1'b0;
    if (!i_rst) begin
      wr_fwd          = (state_reg == S_ISSUE) || (state_reg == S_ACCEPTED) || (state_reg == S_BUSY);
      rd_fwd          = (state_reg == S_ACCEPTED) || (state_reg == S_BUSY);
      o_user_op_type  = op_type_reg;
      o_user_op_addr  = op_addr_reg;
      o_user_op_num   = op_num_reg;
      o_user_op_valid = (state_reg == S_ISSUE);
      o_r0_op_ready   = o_user_op_valid & i_user_op_ready & ~grant_reg;
      o_r1_op_ready   = o_user_op_valid & i_user_op_ready &  grant_reg;
      if (wr_fwd) begin
        o_user_write_data  = grant_reg ? i_r1_write_data  : i_r0_write_data;
        o_user_write_sop   = grant_reg ? i_r1_write_sop   : i_r0_write_sop;
        o_user_write_eop   = grant_reg ? i_r1_write_eop   : i_r0_write_eop;
        o_user_write_valid = grant_reg ? i_r1_write_valid : i_r0_write_valid;
      end
      if (rd_fwd) begin
        if (grant_reg) begin
          o_r1_read_data  = i_user_read_valid ? i_user_read_data : 8'h00;
          o_r1_read_sop   = i_user_read_sop;
          o_r1_read_eop   = i_user_read_eop;
          o_r1_read_valid = i_user_read_valid;
        end else begin
          o_r0_read_data  = i_user_read_valid ? i_user_read_data : 8'h00;
          o_r0_read_sop   = i_user_read_sop;
          o_r0_read_eop   = i_user_read_eop;
          o_r0_read_valid = i_user_read_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_user_arb.sv
// tb_flash_user_arb: directed and randomized checks of flash_user_arb.
// The bench plays both requesters and the flash driver, predicts the winner
// of every arbitration from the round-robin rule and the cycle-exact phase
// sequence of each operation, and checks all outputs every cycle.
module tb_flash_user_arb;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_type [2];
  logic [23:0] req_addr [2];
  logic [8:0]  req_num  [2];
  logic        req_valid[2];
  logic [7:0]  wr_data  [2];
  logic        wr_sop[2], wr_eop[2], wr_valid[2];
  logic        ready;
  logic [7:0]  rd_data;
  logic        rd_sop, rd_eop, rd_valid;

  // outputs of the P_GAP=2 instance (a_) and the P_GAP=0 instance (b_)
  logic a_r0_rdy, a_r1_rdy, a_r0_rs, a_r0_re, a_r0_rv, a_r1_rs, a_r1_re, a_r1_rv;
  logic [7:0] a_r0_rd, a_r1_rd, a_wd;
  logic [1:0] a_type; logic [23:0] a_addr; logic [8:0] a_num; logic a_opv;
  logic a_ws, a_we, a_wv;
  logic b_r0_rdy, b_r1_rdy, b_r0_rs, b_r0_re, b_r0_rv, b_r1_rs, b_r1_re, b_r1_rv;
  logic [7:0] b_r0_rd, b_r1_rd, b_wd;
  logic [1:0] b_type; logic [23:0] b_addr; logic [8:0] b_num; logic b_opv;
  logic b_ws, b_we, b_wv;

  int tests = 0;
  int fails = 0;
  int last  = 1;          // model: last requester served
  int grant_log[$];
  int cnt_wr, cnt_rd0, cnt_rd1;

  always #5 clk = ~clk;

  flash_user_arb #(.P_GAP(GAP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_r0_op_type(req_type[0]), .i_r0_op_addr(req_addr[0]), .i_r0_op_num(req_num[0]),
    .i_r0_op_valid(req_valid[0]), .o_r0_op_ready(a_r0_rdy),
    .i_r0_write_data(wr_data[0]), .i_r0_write_sop(wr_sop[0]), .i_r0_write_eop(wr_eop[0]),
    .i_r0_write_valid(wr_valid[0]),
    .o_r0_read_data(a_r0_rd), .o_r0_read_sop(a_r0_rs), .o_r0_read_eop(a_r0_re), .o_r0_read_valid(a_r0_rv),
    .i_r1_op_type(req_type[1]), .i_r1_op_addr(req_addr[1]), .i_r1_op_num(req_num[1]),
    .i_r1_op_valid(req_valid[1]), .o_r1_op_ready(a_r1_rdy),
    .i_r1_write_data(wr_data[1]), .i_r1_write_sop(wr_sop[1]), .i_r1_write_eop(wr_eop[1]),
    .i_r1_write_valid(wr_valid[1]),
    .o_r1_read_data(a_r1_rd), .o_r1_read_sop(a_r1_rs), .o_r1_read_eop(a_r1_re), .o_r1_read_valid(a_r1_rv),
    .o_user_op_type(a_type), .o_user_op_addr(a_addr), .o_user_op_num(a_num), .o_user_op_valid(a_opv),
    .i_user_op_ready(ready),
    .o_user_write_data(a_wd), .o_user_write_sop(a_ws), .o_user_write_eop(a_we), .o_user_write_valid(a_wv),
    .i_user_read_data(rd_data), .i_user_read_sop(rd_sop), .i_user_read_eop(rd_eop), .i_user_read_valid(rd_valid)
  );

  flash_user_arb #(.P_GAP(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_r0_op_type(req_type[0]), .i_r0_op_addr(req_addr[0]), .i_r0_op_num(req_num[0]),
    .i_r0_op_valid(req_valid[0]), .o_r0_op_ready(b_r0_rdy),
    .i_r0_write_data(wr_data[0]), .i_r0_write_sop(wr_sop[0]), .i_r0_write_eop(wr_eop[0]),
    .i_r0_write_valid(wr_valid[0]),
    .o_r0_read_data(b_r0_rd), .o_r0_read_sop(b_r0_rs), .o_r0_read_eop(b_r0_re), .o_r0_read_valid(b_r0_rv),
    .i_r1_op_type(req_type[1]), .i_r1_op_addr(req_addr[1]), .i_r1_op_num(req_num[1]),
    .i_r1_op_valid(req_valid[1]), .o_r1_op_ready(b_r1_rdy),
    .i_r1_write_data(wr_data[1]), .i_r1_write_sop(wr_sop[1]), .i_r1_write_eop(wr_eop[1]),
    .i_r1_write_valid(wr_valid[1]),
    .o_r1_read_data(b_r1_rd), .o_r1_read_sop(b_r1_rs), .o_r1_read_eop(b_r1_re), .o_r1_read_valid(b_r1_rv),
    .o_user_op_type(b_type), .o_user_op_addr(b_addr), .o_user_op_num(b_num), .o_user_op_valid(b_opv),
    .i_user_op_ready(ready),
    .o_user_write_data(b_wd), .o_user_write_sop(b_ws), .o_user_write_eop(b_we), .o_user_write_valid(b_wv),
    .i_user_read_data(rd_data), .i_user_read_sop(rd_sop), .i_user_read_eop(rd_eop), .i_user_read_valid(rd_valid)
  );

  logic [10:0] a_wr, a_rd0, a_rd1;
  logic [1:0]  a_rdy;
  assign a_wr  = {a_wd, a_ws, a_we, a_wv};
  assign a_rd0 = {a_r0_rd, a_r0_rs, a_r0_re, a_r0_rv};
  assign a_rd1 = {a_r1_rd, a_r1_rs, a_r1_re, a_r1_rv};
  assign a_rdy = {a_r1_rdy, a_r0_rdy};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_streams();
    for (int i = 0; i < 2; i++) begin
      wr_data[i]  = 8'($urandom);
      wr_sop[i]   = 1'($urandom);
      wr_eop[i]   = 1'($urandom);
      wr_valid[i] = 1'($urandom);
    end
    rd_data  = 8'($urandom);
    rd_sop   = 1'($urandom);
    rd_eop   = 1'($urandom);
    rd_valid = 1'($urandom);
  endtask

  task automatic zero_streams();
    for (int i = 0; i < 2; i++) begin
      wr_data[i] = 8'h00; wr_sop[i] = 1'b0; wr_eop[i] = 1'b0; wr_valid[i] = 1'b0;
    end
    rd_data = 8'h00; rd_sop = 1'b0; rd_eop = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic new_request(input int i);
    req_type[i]  = 2'($urandom);
    req_addr[i]  = 24'($urandom);
    req_num[i]   = 9'($urandom);
    req_valid[i] = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_op"},  {a_type, a_addr, a_num, a_opv}, 64'h0);
    chk({tag, "_rdy"}, a_rdy, 64'h0);
    chk({tag, "_wr"},  a_wr,  64'h0);
    chk({tag, "_rd0"}, a_rd0, 64'h0);
    chk({tag, "_rd1"}, a_rd1, 64'h0);
  endtask

  // ph: 0 = no forwarding, 1 = write forwarding only, 2 = write and read forwarding
  task automatic check_cycle(input string tag, input int ph, input int w,
                             input logic exp_opv, input logic [1:0] exp_rdy);
    logic [10:0] beat, ew, er0, er1;
    beat = {rd_valid ? rd_data : 8'h00, rd_sop, rd_eop, rd_valid};
    ew   = (ph >= 1) ? {wr_data[w], wr_sop[w], wr_eop[w], wr_valid[w]} : 11'h0;
    er0  = (ph == 2 && w == 0) ? beat : 11'h0;
    er1  = (ph == 2 && w == 1) ? beat : 11'h0;
    chk({tag, "_opv"}, a_opv, exp_opv);
    chk({tag, "_rdy"}, a_rdy, exp_rdy);
    chk({tag, "_wr"},  a_wr,  ew);
    chk({tag, "_rd0"}, a_rd0, er0);
    chk({tag, "_rd1"}, a_rd1, er1);
    if (a_wv)    cnt_wr++;
    if (a_r0_rv) cnt_rd0++;
    if (a_r1_rv) cnt_rd1++;
  endtask

  function automatic int predict_winner();
    if (req_valid[0] && req_valid[1]) return (last == 0) ? 1 : 0;
    return req_valid[1] ? 1 : 0;
  endfunction

  // mode 0: random streams and request refresh; 1: 4-beat write from the winner
  // with loser junk; 2: 8-beat read to the winner plus a stray beat in the gap.
  task automatic run_op(input int mode, input int stall, input int busy,
                        input bit drop, input bit abort_op);
    int w;
    logic [1:0] e_type; logic [23:0] e_addr; logic [8:0] e_num;
    cnt_wr = 0; cnt_rd0 = 0; cnt_rd1 = 0;
    // IDLE
    @(negedge clk);
    rst = 1'b0;
    if (mode == 0) rand_streams(); else zero_streams();
    if (mode == 1) begin wr_valid[0] = 1'b1; wr_data[0] = 8'($urandom); end
    w = predict_winner();
    e_type = req_type[w]; e_addr = req_addr[w]; e_num = req_num[w];
    #1 check_cycle("idle", 0, w, 1'b0, 2'b00);
    // ISSUE, optionally stalled by the driver
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      ready = (c == stall);
      if (mode == 0) rand_streams(); else zero_streams();
      if (mode == 1) begin wr_valid[1-w] = 1'b1; wr_data[1-w] = 8'($urandom); wr_sop[1-w] = 1'b1; end
      if (drop && c == 0) begin req_valid[w] = 1'b0; req_addr[w] = ~req_addr[w]; req_num[w] = ~req_num[w]; end
      #1 check_cycle("issue", 1, w, 1'b1, ready ? (w == 1 ? 2'b10 : 2'b01) : 2'b00);
      chk("issue_fields", {a_type, a_addr, a_num}, {e_type, e_addr, e_num});
      if (ready) grant_log.push_back(a_r0_rdy ? 0 : (a_r1_rdy ? 1 : 2));
    end
    last = w;
    // ACCEPTED
    @(negedge clk);
    ready = 1'b0;
    if (mode == 0) rand_streams(); else zero_streams();
    if (mode == 1) begin wr_valid[1-w] = 1'b1; wr_data[1-w] = 8'($urandom); end
    #1 check_cycle("acc", 2, w, 1'b0, 2'b00);
    // BUSY
    for (int c = 0; c <= busy; c++) begin
      @(negedge clk);
      if (abort_op) begin
        rst = 1'b1;
        rand_streams();
        #1 check_all_zero("abort");
        last = 1;
        return;
      end
      ready = (c == busy);
      if (mode == 0) rand_streams(); else zero_streams();
      if (mode == 1) begin
        wr_valid[1-w] = 1'b1; wr_data[1-w] = 8'($urandom); wr_eop[1-w] = 1'($urandom);
        if (c < 4) begin
          wr_valid[w] = 1'b1; wr_data[w] = 8'hA0 + 8'(c);
          wr_sop[w] = (c == 0); wr_eop[w] = (c == 3);
        end
      end
      if (mode == 2 && c < 8) begin
        rd_valid = 1'b1; rd_data = 8'h50 + 8'(c); rd_sop = (c == 0); rd_eop = (c == 7);
      end
      if (mode == 0 && c == 0) begin
        if ($urandom_range(0, 1) == 1) new_request(w); else req_valid[w] = 1'b0;
        if (!req_valid[1-w] && $urandom_range(0, 1) == 1) new_request(1 - w);
        if (!req_valid[0] && !req_valid[1]) new_request(1 - w);
      end
      #1 check_cycle("busy", 2, w, 1'b0, 2'b00);
    end
    // GAP
    for (int c = 0; c < GAP; c++) begin
      @(negedge clk);
      if (mode == 0) rand_streams(); else zero_streams();
      if (mode == 2 && c == 0) begin rd_valid = 1'b1; rd_data = 8'hEE; rd_sop = 1'b1; rd_eop = 1'b1; end
      #1 check_cycle("gap", 0, w, 1'b0, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    order = '{0, 1, 0, 1};
    rst = 1'b1; ready = 1'b1;
    zero_streams();
    // reset: outputs stay 0 even with live requests and streams
    req_type[0] = 2'b10; req_addr[0] = 24'h000100; req_num[0] = 9'd16;  req_valid[0] = 1'b1;
    req_type[1] = 2'b01; req_addr[1] = 24'h00F000; req_num[1] = 9'd32;  req_valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rand_streams();
      #1 check_all_zero("reset");
    end
    // both valid at reset release: r0 first, then r1 after busy and gap; then alternation
    grant_log.delete();
    run_op(0, 0, 2, 1'b0, 1'b0);
    req_addr[0] = 24'h000200;
    run_op(0, 1, 1, 1'b0, 1'b0);
    req_addr[0] = 24'h000300;
    run_op(0, 0, 0, 1'b0, 1'b0);
    run_op(0, 2, 3, 1'b0, 1'b0);
    chk("order_len", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("order", grant_log[i], order[i]);
    // r1 page write of 4 bytes while r0 drives junk
    req_valid[0] = 1'b0;
    req_type[1] = 2'b01; req_addr[1] = 24'h012300; req_num[1] = 9'd4; req_valid[1] = 1'b1;
    run_op(1, 1, 4, 1'b0, 1'b0);
    chk("write_beats", cnt_wr, 4);
    // r0 read of 8 beats, request withdrawn after grant, stray beat in gap
    req_valid[1] = 1'b0;
    req_type[0] = 2'b00; req_addr[0] = 24'h045600; req_num[0] = 9'd8; req_valid[0] = 1'b1;
    run_op(2, 0, 8, 1'b1, 1'b0);
    chk("read_beats_r0", cnt_rd0, 8);
    chk("read_valid_r1", cnt_rd1, 0);
    // reset during BUSY of an r0 op, then a tie must go to r0
    new_request(0); req_valid[1] = 1'b0;
    run_op(0, 0, 3, 1'b0, 1'b1);
    new_request(0); new_request(1);
    grant_log.delete();
    run_op(0, 0, 1, 1'b0, 1'b0);
    chk("post_reset_grant", grant_log.size() > 0 ? grant_log[0] : 2, 0);
    // randomized operations
    for (int n = 0; n < 25; n++)
      run_op(0, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
    // P_GAP=0 instance reaches IDLE right after BUSY, the P_GAP=2 one two cycles later
    @(negedge clk); rst = 1'b1; zero_streams();
    req_valid[0] = 1'b0; req_type[1] = 2'b11; req_addr[1] = 24'h0ABCDE; req_num[1] = 9'd1; req_valid[1] = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); ready = 1'b1;
    #1 chk("p0_issue_opv", b_opv, 1'b1);
    chk("p0_issue_addr", b_addr, 24'h0ABCDE);
    chk("p2_issue_opv", a_opv, 1'b1);
    @(negedge clk); ready = 1'b0;
    @(negedge clk); ready = 1'b1;
    @(negedge clk); #1 chk("p0_idle_opv", b_opv, 1'b0);
    chk("p2_gap1_opv", a_opv, 1'b0);
    @(negedge clk); #1 chk("p0_reissue_opv", b_opv, 1'b1);
    chk("p2_gap2_opv", a_opv, 1'b0);
    @(negedge clk); #1 chk("p2_idle_opv", a_opv, 1'b0);
    @(negedge clk); #1 chk("p2_reissue_opv", a_opv, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
